// File: rtl/fuse_flow_ctrl_pkg.sv
// Shared types and default widths for the fuse-stage flow controller.
//   FlowState : RUN / FLUSH / WAIT_REDIR recovery state (value 3 is unused and decodes to RUN)
//   ENQ_W / DEQ_W / OCC_W : widths of the enqueue count, dequeue count and occupancy
//                           for the default build (4 in, 3 out, 8 entries)
package fuse_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        WAIT_REDIR = 2'd2
    } FlowState;

    localparam int unsigned DEF_NUM_UOPS_IN  = 4;
    localparam int unsigned DEF_NUM_UOPS_OUT = 3;
    localparam int unsigned DEF_BUF_SIZE     = 8;

    localparam int unsigned ENQ_W = $clog2(DEF_NUM_UOPS_IN + 1);
    localparam int unsigned DEQ_W = $clog2(DEF_NUM_UOPS_OUT + 1);
    localparam int unsigned OCC_W = $clog2(DEF_BUF_SIZE + 1);

endpackage

// File: rtl/fuse_flow_ctrl.sv
// Flow-control and mispredict-recovery sequencer for the fuse stage output uop buffer.
// Tracks buffer occupancy, grants dequeue slots to rename, raises back-pressure and
// sequences flush -> wait-for-redirect -> resume after a mispredict.
// Ports:
//   clk             : clock, rising edge
//   rst             : asynchronous active-low reset
//   IN_mispredict   : branch mispredict (outranks all other inputs)
//   IN_redirectAck  : fetch has redirected
//   IN_enqCnt       : uops written by the fuse stage this cycle
//   IN_backendReady : rename accepts uops this cycle
//   OUT_deqCnt      : uops granted to rename this cycle (combinational)
//   OUT_full        : back-pressure to the fuse stage (registered)
//   OUT_flush       : invalidate fuse pipeline and buffer (registered)
//   OUT_occupancy   : valid buffer entries (registered)
//   OUT_state       : current FlowState
//   OUT_overflow    : sticky, set when an enqueue would exceed BUF_SIZE
module fuse_flow_ctrl
    import fuse_flow_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UOPS_IN  = 4,
    parameter int unsigned NUM_UOPS_OUT = 3,
    parameter int unsigned BUF_SIZE     = 8,
    parameter int unsigned FULL_THRESH  = 5,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              IN_mispredict,
    input  logic                              IN_redirectAck,
    input  logic [$clog2(NUM_UOPS_IN+1)-1:0]  IN_enqCnt,
    input  logic                              IN_backendReady,
    output logic [$clog2(NUM_UOPS_OUT+1)-1:0] OUT_deqCnt,
    output logic                              OUT_full,
    output logic                              OUT_flush,
    output logic [$clog2(BUF_SIZE+1)-1:0]     OUT_occupancy,
    output logic [1:0]                        OUT_state,
    output logic                              OUT_overflow
);

    localparam int unsigned EW   = $clog2(NUM_UOPS_IN + 1);
    localparam int unsigned DW   = $clog2(NUM_UOPS_OUT + 1);
    localparam int unsigned OW   = $clog2(BUF_SIZE + 1);
    localparam int unsigned SW   = OW + 1;
    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    FlowState         state_q, state_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [FC_W-1:0]  cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             full_q, full_d;
    logic             flush_q, flush_d;
    logic             ovf_q, ovf_d;

    logic             is_run;
    logic [DW-1:0]    deq_cnt;
    logic [EW-1:0]    enq_acc;
    logic [SW-1:0]    occ_sum;
    logic             over;
    logic [OW-1:0]    occ_sat;

    always_comb begin
        // The unused encoding behaves exactly like RUN.
        is_run  = (state_q != FLUSH) && (state_q != WAIT_REDIR);

        deq_cnt = '0;
        if (is_run && IN_backendReady)
            deq_cnt = (32'(occ_q) > NUM_UOPS_OUT) ? DW'(NUM_UOPS_OUT) : DW'(occ_q);

        enq_acc = (is_run && !full_q) ? IN_enqCnt : '0;

        // One bit wider than occ so an over-enqueue is visible before saturation.
        occ_sum = SW'(occ_q) + SW'(enq_acc) - SW'(deq_cnt);
        over    = (32'(occ_sum) > BUF_SIZE);
        occ_sat = over ? OW'(BUF_SIZE) : OW'(occ_sum);

        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        occ_d   = occ_sat;
        ovf_d   = ovf_q | over;

        case (state_q)
            FLUSH: begin
                if (IN_redirectAck)
                    ack_d = 1'b1;
                if (cnt_q == '0)
                    state_d = (ack_q || IN_redirectAck) ? RUN : WAIT_REDIR;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            WAIT_REDIR: begin
                if (IN_redirectAck)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Mispredict wins over everything; this cycle's enq/deq are dropped.
        if (IN_mispredict) begin
            state_d = FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES - 1);
            ack_d   = 1'b0;
            occ_d   = '0;
            ovf_d   = ovf_q;
        end

        full_d  = (state_d != RUN) || ((BUF_SIZE - 32'(occ_d)) < FULL_THRESH);
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            occ_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            full_q  <= 1'b0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            full_q  <= full_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT_deqCnt    = deq_cnt;
    assign OUT_full      = full_q;
    assign OUT_flush     = flush_q;
    assign OUT_occupancy = occ_q;
    assign OUT_state     = state_q;
    assign OUT_overflow  = ovf_q;

endmodule

// File: tb/tb_fuse_flow_ctrl.sv
// Scoreboard bench for fuse_flow_ctrl: the driver pushes hand-computed expectations,
// a monitor samples the DUT each cycle and pops/compares them.
module tb_fuse_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       IN_mispredict = 1'b0;
    logic       IN_redirectAck = 1'b0;
    logic [2:0] IN_enqCnt = '0;
    logic       IN_backendReady = 1'b0;

    logic [1:0] a_deq, b_deq;
    logic       a_full, b_full, a_flush, b_flush, a_ovf, b_ovf;
    logic [3:0] a_occ, b_occ;
    logic [1:0] a_st, b_st;

    always #5 clk = ~clk;

    fuse_flow_ctrl #(
        .NUM_UOPS_IN(4), .NUM_UOPS_OUT(3), .BUF_SIZE(8), .FULL_THRESH(5), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .IN_mispredict(IN_mispredict), .IN_redirectAck(IN_redirectAck),
        .IN_enqCnt(IN_enqCnt), .IN_backendReady(IN_backendReady), .OUT_deqCnt(a_deq),
        .OUT_full(a_full), .OUT_flush(a_flush), .OUT_occupancy(a_occ), .OUT_state(a_st),
        .OUT_overflow(a_ovf)
    );

    fuse_flow_ctrl #(
        .NUM_UOPS_IN(4), .NUM_UOPS_OUT(3), .BUF_SIZE(8), .FULL_THRESH(0), .FLUSH_CYCLES(2)
    ) dut_nothresh (
        .clk(clk), .rst(rst), .IN_mispredict(IN_mispredict), .IN_redirectAck(IN_redirectAck),
        .IN_enqCnt(IN_enqCnt), .IN_backendReady(IN_backendReady), .OUT_deqCnt(b_deq),
        .OUT_full(b_full), .OUT_flush(b_flush), .OUT_occupancy(b_occ), .OUT_state(b_st),
        .OUT_overflow(b_ovf)
    );

    typedef struct {
        int    cyc;
        bit    sel;
        string name;
        int    deq, full, flush, occ, st, ovf;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input int ex);
        n_total++;
        if (act === 32'(ex)) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, ex);
    endtask

    // Inputs are applied at the falling edge; the expectation describes deqCnt in that
    // cycle and the registered outputs just after the following rising edge.
    task automatic step(input string nm, input bit sel, input bit rn, input bit misp,
                        input bit ack, input int enq, input bit rdy,
                        input int edeq, input int efull, input int eflush,
                        input int eocc, input int est, input int eovf);
        exp_t e;
        @(negedge clk);
        rst             = rn;
        IN_mispredict   = misp;
        IN_redirectAck  = ack;
        IN_enqCnt       = 3'(enq);
        IN_backendReady = rdy;
        e.cyc = cyc + 1; e.sel = sel; e.name = nm;
        e.deq = edeq; e.full = efull; e.flush = eflush; e.occ = eocc; e.st = est; e.ovf = eovf;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        logic [1:0] da, db;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            da = a_deq;
            db = b_deq;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (!e.sel) begin
                    chk(e.name, "deq",   32'(da),      e.deq);
                    chk(e.name, "full",  32'(a_full),  e.full);
                    chk(e.name, "flush", 32'(a_flush), e.flush);
                    chk(e.name, "occ",   32'(a_occ),   e.occ);
                    chk(e.name, "state", 32'(a_st),    e.st);
                    chk(e.name, "ovf",   32'(a_ovf),   e.ovf);
                end else begin
                    chk(e.name, "deq",   32'(db),      e.deq);
                    chk(e.name, "full",  32'(b_full),  e.full);
                    chk(e.name, "flush", 32'(b_flush), e.flush);
                    chk(e.name, "occ",   32'(b_occ),   e.occ);
                    chk(e.name, "state", 32'(b_st),    e.st);
                    chk(e.name, "ovf",   32'(b_ovf),   e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    // Driver: name, sel, rst_n, misp, ack, enq, rdy | deq, full, flush, occ, state, ovf
    initial begin
        step("reset",        0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // back-pressure
        step("enq4",         0, 1, 0, 0, 4, 0,  0, 1, 0, 4, 0, 0);
        step("enq4_blocked", 0, 1, 0, 0, 4, 0,  0, 1, 0, 4, 0, 0);
        // dequeue
        step("deq3",         0, 1, 0, 0, 0, 1,  3, 0, 0, 1, 0, 0);
        step("deq1",         0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        step("deq_empty",    0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        // simultaneous enq + deq
        step("enq2",         0, 1, 0, 0, 2, 0,  0, 0, 0, 2, 0, 0);
        step("enq3_deq2",    0, 1, 0, 0, 3, 1,  2, 0, 0, 3, 0, 0);
        // mispredict recovery
        step("fill6",        0, 1, 0, 0, 3, 0,  0, 1, 0, 6, 0, 0);
        step("misp",         0, 1, 1, 0, 2, 0,  0, 1, 1, 0, 1, 0);
        step("flush2",       0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("wait",         0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
        step("wait_hold",    0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
        step("redir",        0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        // early ack during flush, then re-mispredicts
        step("misp_b",       0, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("ack_in_flush", 0, 1, 0, 1, 0, 0,  0, 1, 1, 0, 1, 0);
        step("ack_resume",   0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("run_enq2",     0, 1, 0, 0, 2, 0,  0, 0, 0, 2, 0, 0);
        step("misp_run",     0, 1, 1, 0, 0, 1,  2, 1, 1, 0, 1, 0);
        step("restart_f2",   0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("wait_b",       0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
        step("misp_wait",    0, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("restart_f2b",  0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("wait_enq_ign", 0, 1, 0, 0, 4, 1,  0, 1, 0, 0, 2, 0);
        // reset in the middle of a flush
        step("misp_c",       0, 1, 1, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        step("rst_mid",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("post_rst",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // overflow on the FULL_THRESH=0 build
        step("nt_enq4",      1, 1, 0, 0, 4, 0,  0, 0, 0, 4, 0, 0);
        step("nt_enq3",      1, 1, 0, 0, 3, 0,  0, 0, 0, 7, 0, 0);
        step("nt_overflow",  1, 1, 0, 0, 4, 0,  0, 0, 0, 8, 0, 1);
        step("nt_deq3",      1, 1, 0, 0, 0, 1,  3, 0, 0, 5, 0, 1);
        step("nt_sticky",    1, 1, 0, 0, 0, 0,  0, 0, 0, 5, 0, 1);
        step("nt_idle",      1, 1, 0, 0, 0, 0,  0, 0, 0, 5, 0, 1);

        @(negedge clk);
        IN_enqCnt = '0;
        IN_backendReady = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
